// File: rtl/digit_scan_mux.sv
// Time-multiplexed BCD digit scanner feeding the 7-segment decoder.
// Per-slot prescaler, anode dead time at each slot change, optional leading-zero blanking.
module digit_scan_mux #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int DEAD     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic                  blank_lz,
   output logic [3:0]            bcd_out,
   output logic [DIGITS-1:0]     an,
   output logic                  slot_tick
);

   localparam int CW = $clog2(PRESCALE);
   localparam int SW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] DEAD_END  = CW'(DEAD);
   localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

   logic [4*DIGITS-1:0] sh;
   logic [CW-1:0]       cnt;
   logic [SW-1:0]       slot;

   logic                wrap;
   logic                dead;
   logic                blank;
   logic [3:0]          digit_sel;
   logic [DIGITS-1:0]   zero_from;
   logic [DIGITS-1:0]   an_next;

   assign wrap = (cnt == CNT_LAST);
   assign dead = (DEAD != 0) && (cnt < DEAD_END);

   // zero_from[i]: digits i..DIGITS-1 are all zero, i.e. slot i is a leading zero
   always_comb begin
      zero_from = '0;
      for (int i = 0; i < DIGITS; i++) begin
         logic acc;
         acc = 1'b1;
         for (int j = i; j < DIGITS; j++) begin
            if (sh[4*j +: 4] != 4'd0) acc = 1'b0;
         end
         zero_from[i] = acc;
      end
   end

   always_comb begin
      digit_sel = 4'd0;
      blank     = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (slot == SW'(i)) begin
            digit_sel = sh[4*i +: 4];
            blank     = blank_lz && (i != 0) && zero_from[i];
         end
      end
   end

   always_comb begin
      an_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((slot == SW'(i)) && !dead && !blank) an_next[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh        <= '0;
         cnt       <= '0;
         slot      <= '0;
         bcd_out   <= 4'd0;
         an        <= '1;
         slot_tick <= 1'b0;
      end else begin
         if (load) sh <= digits_in;
         if (wrap) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
         end else begin
            cnt  <= cnt + CW'(1);
         end
         slot_tick <= wrap;
         bcd_out   <= digit_sel;
         an        <= an_next;
      end
   end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Time-multiplexing scanner for the Simon score/status display. It latches a packed word of BCD digits and cycles through them one at a time. Each digit's 4-bit code goes to the 7-segment decoder's `in` input, and the scanner drives the matching active-low digit anode. The block sits directly upstream of the segment decoder and adds three display features: a per-slot prescaler, anti-ghosting dead time at each slot change, and optional leading-zero blanking.

## Interface
- `DIGITS`, 4, number of multiplexed digits; legal range 2..8.
- `PRESCALE`, 50000, clock cycles per digit slot; must be ≥ 2.
- `DEAD`, 16, cycles at the start of each slot with all anodes off; 0 ≤ DEAD < PRESCALE.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `load`  input  1  when high at a clock edge, `digits_in` is captured into the shadow register.
- `digits_in`  input  4*DIGITS  packed BCD; bits [4i+3:4i] hold digit i, where digit 0 is least significant.
- `blank_lz`  input  1  enables leading-zero blanking; sampled every cycle, not latched.
- `bcd_out`  output  4  current digit code, connected to the decoder `in`.
- `an`  output  DIGITS  active-low one-hot digit enable; all ones means dark.
- `slot_tick`  output  1  one-cycle pulse each time the slot index advances.

## Operation
- State:
  - shadow register `sh`, 4*DIGITS bits;
  - prescaler `cnt`, counts 0..PRESCALE-1;
  - slot index `slot`, counts 0..DIGITS-1.
- Prescaler: `cnt` increments every cycle. When `cnt` is PRESCALE-1, it wraps to 0 and `slot` advances. `slot` wraps from DIGITS-1 to 0.
- Shadow register: `sh` is written only on edges where `load`=1. A load does not touch `cnt` or `slot`. Digit codes 10–15 pass through unchanged.
- Blank condition for slot i: `blank_lz`=1, and i≠0, and every digit j with i ≤ j ≤ DIGITS-1 is zero in `sh`.
  - Consequence: digit 0 is never blanked, so an all-zero value shows a single "0".
- Output function f(slot, cnt, sh, blank_lz):
  - `bcd_out` = sh digit[slot]. It is driven even during dead time and blanking; gating is done only through `an`.
  - `an` = all ones if cnt < DEAD or slot i is blanked; otherwise bit `slot` is low and all other bits are high.
- Outputs are registered. The values seen after edge k equal f evaluated on the state before edge k.
- `slot_tick` is registered. It is high for the single cycle following the edge on which `slot` advanced.
- Reset: while `rst`=1, regardless of clock:
  - `sh`=0, `cnt`=0, `slot`=0;
  - `an`=all ones, `bcd_out`=0, `slot_tick`=0.
  - Reset overrides a simultaneous `load`.

## Timing
- Edges are counted from reset release; edge 1 is the first rising edge with `rst`=0.
- Slot 0 anode asserts on edge DEAD+1. With DEAD=0, it asserts on edge 1.
- `slot` advances on edge PRESCALE. `slot_tick` is high between edges PRESCALE and PRESCALE+1.
- Slot n's anode is low from edge n·PRESCALE+DEAD+1 through edge (n+1)·PRESCALE.
- Full scan period is DIGITS·PRESCALE cycles.
- Load latency: data presented with `load` at edge k appears on `bcd_out`/`an` after edge k+1.
- Load during dead time or mid-slot: takes effect at the normal latency. No glitch other than the digit value changing.
- Asynchronous reset mid-slot forces all outputs to their reset values immediately, without a clock. Scanning restarts at slot 0 per the timeline above.
- A `blank_lz` toggle is reflected after one edge.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=8, DEAD=2.

1. **Reset hold:** `rst`=1 for 5 cycles with `load`=1 and `digits_in`=16'h9999 → `an`=4'b1111, `bcd_out`=0, `slot_tick`=0 throughout. After release, the first non-1111 `an` is 4'b1110 with `bcd_out`=0 on edge 3.
2. **Full scan:** load 16'h1234, `blank_lz`=0 → output sequence:
   - slot 0: `bcd_out`=4, `an`=1110;
   - slot 1: `bcd_out`=3, `an`=1101;
   - slot 2: `bcd_out`=2, `an`=1011;
   - slot 3: `bcd_out`=1, `an`=0111.
   - Each slot is 8 cycles, of which the first 2 have `an`=1111.
   - `slot_tick` pulses every 8 cycles; the sequence repeats after 32 cycles.
3. **Leading-zero blanking:** load 16'h0050 with `blank_lz`=1 → slots 3 and 2 show `an`=1111; slot 1 shows 5 with `an`=1101; slot 0 shows 0 with `an`=1110. Then load 16'h0000 → only slot 0 lights, with `bcd_out`=0. Then drop `blank_lz` → all four slots light with 0.
4. **Code passthrough:** load 16'hF0A0 with `blank_lz`=1 → no slot is blanked, because digit 3 is nonzero; `bcd_out` cycles 0, A, 0, F.
5. **Mid-slot load:** load 16'h1111, then load 16'h2222 at cycle 5 of slot 1 → `bcd_out`=2 appears one edge later. `slot_tick` spacing stays at 8 cycles and the anode pattern is unchanged.
6. **Asynchronous reset mid-slot 2:** assert `rst` between clock edges → `an`=1111 and `bcd_out`=0 before the next edge, and `sh` is cleared. After release, the timeline restarts at slot 0 with value 0.
